// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, mode constants and the slave state encoding.
// Also intended for a companion spi_master.
package spi_pkg;

    localparam int SPI_FRAME_W = 8;
    localparam int SPI_CNT_W   = $clog2(SPI_FRAME_W);

    localparam logic       SPI_CPOL  = 1'b0;
    localparam logic       SPI_CPHA  = 1'b0;
    localparam logic [1:0] SPI_MODE0 = {SPI_CPOL, SPI_CPHA};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    // MSB-first shift: the new bit enters at the LSB.
    function automatic logic [SPI_FRAME_W-1:0] spi_shl(input logic [SPI_FRAME_W-1:0] v,
                                                       input logic b);
        return {v[SPI_FRAME_W-2:0], b};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on clk_sys-domain clk, with a one-entry transmit buffer.
// state    | meaning
// IDLE     | cs_n high: sclk ignored, miso tri-stated (driven 0, oe low)
// SHIFT    | cs_n low: shift bytes on sclk, reload tx after each 8th bit
module spi_slave
    import spi_pkg::*;
#(
    parameter int                     SYNC_STAGES = 2,
    parameter logic [SPI_FRAME_W-1:0] IDLE_BYTE   = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sclk,
    input  logic                   cs_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [SPI_FRAME_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SPI_FRAME_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   tx_underrun,
    output logic                   busy
);

    logic sclk_s, cs_n_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
    );

    spi_state_e             state_q, state_d;
    logic                   sclk_hist_q, cs_n_hist_q;
    logic [SPI_FRAME_W-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_FRAME_W-1:0] buf_q, buf_d;
    logic [SPI_FRAME_W-1:0] rx_data_q, rx_data_d;
    logic [SPI_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   buf_full_q, buf_full_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   sclk_rise, sclk_fall, cs_fall, load;

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = cs_n_hist_q & ~cs_n_s;

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_n_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                end else if (sclk_rise) begin
                    rx_sr_d   = spi_shl(rx_sr_q, mosi_s);
                    bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
                    if (bit_cnt_q == SPI_CNT_W'(SPI_FRAME_W - 1)) begin
                        rx_data_d  = spi_shl(rx_sr_q, mosi_s);
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Counter back at zero on a fall means the byte just completed.
                    if (bit_cnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        tx_sr_d = spi_shl(tx_sr_q, 1'b0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (buf_full_q) begin
                tx_sr_d    = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_sr_d    = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        // A consume only happens while full, so it never coincides with an accepted write.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_hist_q <= 1'b0;
            cs_n_hist_q <= 1'b1;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_hist_q <= sclk_s;
            cs_n_hist_q <= cs_n_s;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign miso_oe     = busy && !cs_n_s;
    assign miso        = miso_oe ? tx_sr_q[SPI_FRAME_W-1] : 1'b0;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, corner-case sequences and
// randomized bursts checked against a byte-order model of the transmit/receive streams.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi, miso, miso_oe;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    int underrun_cnt = 0;
    int wr_cnt       = 0;

    spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observe pulses and accepted writes away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (tx_underrun) underrun_cnt++;
            if (tx_valid && tx_ready) wr_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("tx_write_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            mosi = mo[b];
            clk_wait(half);
            mi[b] = miso;
            sclk  = 1'b1;
            clk_wait(half);
            sclk  = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        clk_wait(8);
    endtask

    task automatic cs_end();
        clk_wait(4);
        cs_n = 1'b1;
        clk_wait(8);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       wr;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        int         exp_ur;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] mi, m0, m1;
    logic [7:0] feed[5];
    logic [7:0] fmo[4];
    logic [7:0] fmi[4];
    int         u0, w0;

    task automatic feeder();
        for (int k = 0; k < 5; k++) begin
            bit ok;
            ok = 1'b0;
            tx_data  = feed[k];
            tx_valid = 1'b1;
            for (int i = 0; i < 4000 && !ok; i++) begin
                @(negedge clk);
                if (tx_ready) ok = 1'b1;
            end
            @(posedge clk);
            #1;
            check("feed_accept", {31'd0, ok}, 32'd1);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b0, 8'h55, 8'h00, 1};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 8'h7E, 8'h81, 0};
        vecs[4] = '{8'h5A, 1'b0, 8'hC3, 8'h00, 1};
        feed    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        clk_wait(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        clk_wait(4);

        // Directed single-byte frames; every frame also ends with a reload from an empty buffer.
        for (int i = 0; i < 5; i++) begin
            rx_q.delete();
            u0 = underrun_cnt;
            if (vecs[i].wr) write_tx(vecs[i].tx);
            cs_begin();
            check("vec_busy", {31'd0, busy}, 32'd1);
            check("vec_miso_oe", {31'd0, miso_oe}, 32'd1);
            check("vec_underrun_at_cs", underrun_cnt - u0, vecs[i].exp_ur);
            spi_bits(vecs[i].mo, 8, 4, mi);
            cs_end();
            check("vec_master_rx", {24'd0, mi}, {24'd0, vecs[i].exp_mi});
            check("vec_rx_count", rx_q.size(), 1);
            if (rx_q.size() > 0) check("vec_rx_byte", {24'd0, rx_q[0]}, {24'd0, vecs[i].mo});
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[i].mo});
            check("vec_underrun_total", underrun_cnt - u0, vecs[i].exp_ur + 1);
            check("vec_idle_busy", {31'd0, busy}, 32'd0);
            check("vec_idle_oe", {31'd0, miso_oe}, 32'd0);
            check("vec_idle_miso", {31'd0, miso}, 32'd0);
        end

        // Two bytes in one chip-select, second byte written while the first shifts.
        rx_q.delete();
        write_tx(8'h12);
        cs_begin();
        fork
            begin
                spi_bits(8'hF0, 8, 4, m0);
                spi_bits(8'h0F, 8, 4, m1);
            end
            begin
                clk_wait(12);
                write_tx(8'h34);
            end
        join
        cs_end();
        check("b2b_miso0", {24'd0, m0}, 32'h12);
        check("b2b_miso1", {24'd0, m1}, 32'h34);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", {24'd0, rx_q[0]}, 32'hF0);
            check("b2b_rx1", {24'd0, rx_q[1]}, 32'h0F);
        end

        // Abort after 5 bits: partial byte dropped, buffered byte survives.
        rx_q.delete();
        u0 = underrun_cnt;
        cs_begin();
        write_tx(8'h6D);
        spi_bits(8'hFF, 5, 4, mi);
        clk_wait(4);
        cs_n = 1'b1;
        clk_wait(8);
        check("abort_rx_count", rx_q.size(), 0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_underrun", underrun_cnt - u0, 1);
        check("abort_buf_kept", {31'd0, tx_ready}, 32'd0);
        cs_begin();
        spi_bits(8'hC3, 8, 4, mi);
        cs_end();
        check("abort_next_miso", {24'd0, mi}, 32'h6D);
        check("abort_next_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("abort_next_rx", {24'd0, rx_q[0]}, 32'hC3);

        // Reset in the middle of a frame.
        write_tx(8'h77);
        cs_begin();
        spi_bits(8'hB4, 3, 4, mi);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {18'd0, miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy},
              {18'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        clk_wait(3);
        cs_n = 1'b1;
        sclk = 1'b0;
        rst_n = 1'b1;
        clk_wait(4);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rx_q.delete();
        write_tx(8'h99);
        cs_begin();
        spi_bits(8'h24, 8, 4, mi);
        cs_end();
        check("midrst_next_miso", {24'd0, mi}, 32'h99);
        check("midrst_next_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("midrst_next_rx", {24'd0, rx_q[0]}, 32'h24);

        // tx_valid held continuously: one write per reload, order preserved.
        rx_q.delete();
        u0 = underrun_cnt;
        w0 = wr_cnt;
        for (int k = 0; k < 4; k++) fmo[k] = 8'($urandom);
        fork
            feeder();
            begin
                clk_wait(6);
                check("hold_ready_before", {31'd0, tx_ready}, 32'd0);
                cs_begin();
                check("hold_ready_in_frame", {31'd0, tx_ready}, 32'd0);
                for (int k = 0; k < 4; k++) spi_bits(fmo[k], 8, 4, fmi[k]);
                cs_end();
            end
        join
        for (int k = 0; k < 4; k++) check("hold_miso", {24'd0, fmi[k]}, {24'd0, feed[k]});
        check("hold_writes", wr_cnt - w0, 5);
        check("hold_underrun", underrun_cnt - u0, 0);
        check("hold_ready_after", {31'd0, tx_ready}, 32'd1);
        check("hold_rx_count", rx_q.size(), 4);
        if (rx_q.size() == 4)
            for (int k = 0; k < 4; k++) check("hold_rx", {24'd0, rx_q[k]}, {24'd0, fmo[k]});

        // Randomized bursts against the stream model: bytes leave in write order,
        // any load with an empty buffer sends IDLE_BYTE and counts an underrun.
        for (int r = 0; r < 15; r++) begin
            int         n, half, exp_ur;
            logic [7:0] wr[3];
            logic [7:0] mo[3];
            bit         has[3];
            n    = $urandom_range(1, 3);
            half = $urandom_range(4, 7);
            exp_ur = 1;
            for (int k = 0; k < 3; k++) begin
                wr[k]  = 8'($urandom);
                mo[k]  = 8'($urandom);
                has[k] = ($urandom_range(0, 3) != 0);
                if (k < n && !has[k]) exp_ur++;
            end
            rx_q.delete();
            u0 = underrun_cnt;
            if (has[0]) write_tx(wr[0]);
            cs_begin();
            for (int k = 0; k < n; k++) begin
                if (k > 0) clk_wait(6);
                if (k + 1 < n && has[k+1]) write_tx(wr[k+1]);
                spi_bits(mo[k], 8, half, mi);
                check("rand_miso", {24'd0, mi}, has[k] ? {24'd0, wr[k]} : 32'h00);
            end
            cs_end();
            check("rand_rx_count", rx_q.size(), n);
            if (rx_q.size() == n)
                for (int k = 0; k < n; k++) check("rand_rx", {24'd0, rx_q[k]}, {24'd0, mo[k]});
            check("rand_underrun", underrun_cnt - u0, exp_ur);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
